// File: rtl/pattern_tx_scheduler_pkg.sv
// Shared definitions for pattern_tx_scheduler.
// Contents:
//   state_e  - FSM state encoding (IDLE / SHIFT / GAP)
//   cnt_w()  - width of a counter that must hold values 0..n-1 (never below 1)
//   *_DEF    - default parameter values and the counter widths they imply
package pattern_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned N_REQ_DEF     = 4;
    localparam int unsigned PAT_W_DEF     = 8;
    localparam int unsigned GAP_CYC_DEF   = 2;
    localparam int unsigned BIT_CNT_W_DEF = cnt_w(PAT_W_DEF);
    localparam int unsigned GAP_CNT_W_DEF = cnt_w(GAP_CYC_DEF);

endpackage

// File: rtl/pattern_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req_i   - request vector
//   ptr_i   - index of the previous winner; search starts at ptr_i+1 and wraps
//   gnt_o   - one-hot winner (all zero when nothing requests)
//   idx_o   - binary index of the winner
//   valid_o - at least one request is present
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int k;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        // Offsets 1..N_REQ visit every requester once, the previous winner last.
        for (int i = 1; i <= int'(N_REQ); i++) begin
            k = (int'(ptr_i) + i) % int'(N_REQ);
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                idx_o    = PTR_W'(k);
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_tx_scheduler.sv
// pattern_tx_scheduler: round-robin time-sharing of one serial line.
// Each grant shifts the winner's PAT_W-bit pattern out MSB-first, then
// holds the line idle for GAP_CYC cycles before arbitrating again.
// Ports:
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   req_i          - per-requester request level
//   pat_i          - patterns, requester k at [k*PAT_W +: PAT_W]
//   gnt_o          - one-cycle one-hot grant, coincident with the first bit
//   ser_o          - serial bit; ser_valid_o marks pattern bits
//   done_o         - pulse with the last bit
//   busy_o         - high while in SHIFT or GAP
module pattern_tx_scheduler
    import pattern_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned PAT_W   = PAT_W_DEF,
    parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*PAT_W-1:0] pat_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic                   ser_o,
    output logic                   ser_valid_o,
    output logic                   done_o,
    output logic                   busy_o
);

    localparam int unsigned PTR_W = cnt_w(N_REQ);
    localparam int unsigned BIT_W = cnt_w(PAT_W);
    localparam int unsigned GAP_W = cnt_w(GAP_CYC);

    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   sreg_q, sreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               ser_q, ser_d;
    logic               ser_valid_q, ser_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [PAT_W-1:0]   win_pat;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_vld)
    );

    assign win_pat = pat_i[int'(arb_idx)*PAT_W +: PAT_W];

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        ser_d       = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The MSB goes out on the grant edge itself, so the register
                // keeps the full pattern and the next bit is read one below MSB.
                if (arb_vld) begin
                    sreg_d      = win_pat;
                    gnt_d       = arb_gnt;
                    ser_d       = win_pat[PAT_W-1];
                    ser_valid_d = 1'b1;
                    bit_cnt_d   = BIT_LAST;
                    ptr_d       = arb_idx;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // bit_cnt_q counts the bits still to follow the one on the line.
                if (bit_cnt_q != '0) begin
                    sreg_d      = sreg_q << 1;
                    ser_d       = sreg_q[PAT_W-2];
                    ser_valid_d = 1'b1;
                    bit_cnt_d   = bit_cnt_q - 1'b1;
                    done_d      = (bit_cnt_q == BIT_W'(1));
                end else begin
                    sreg_d = '0;
                    if (GAP_CYC > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ptr_q       <= PTR_RST;
            gnt_q       <= '0;
            ser_q       <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ser_q       <= ser_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ser_o       = ser_q;
    assign ser_valid_o = ser_valid_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pattern_tx_scheduler.sv
// Bench for pattern_tx_scheduler: a GAP_CYC=2 instance (dut0) and a
// GAP_CYC=0 instance (dut1), both checked every cycle against a
// transaction-level model (winner + time offset into the transfer).
module tb_pattern_tx_scheduler;

    localparam int N  = 4;
    localparam int PW = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req0, req1;
    logic [31:0] pat0, pat1;
    logic [3:0]  gnt0, gnt1;
    logic        ser0, ser1, sv0, sv1, done0, done1, busy0, busy1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    pattern_tx_scheduler #(.N_REQ(4), .PAT_W(8), .GAP_CYC(2)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .pat_i(pat0),
        .gnt_o(gnt0), .ser_o(ser0), .ser_valid_o(sv0), .done_o(done0), .busy_o(busy0)
    );

    pattern_tx_scheduler #(.N_REQ(4), .PAT_W(8), .GAP_CYC(0)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .pat_i(pat1),
        .gnt_o(gnt1), .ser_o(ser1), .ser_valid_o(sv1), .done_o(done1), .busy_o(busy1)
    );

    // Model: last winner, and the offset t (in cycles) since the grant edge.
    typedef struct {
        int         ptr;
        bit         active;
        int         t;
        int         win;
        logic [7:0] cur;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mreset();
        mdl_t m;
        m.ptr = N - 1; m.active = 0; m.t = 0; m.win = 0; m.cur = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic [3:0] req,
                                   input logic [31:0] pat, input int gap);
        mdl_t n = m;
        if (n.active) begin
            n.t++;
            if (n.t >= PW + gap) n.active = 0;
        end else if (req != 4'b0) begin
            for (int i = 1; i <= N; i++)
                if (!n.active && req[(m.ptr + i) % N]) begin
                    n.win    = (m.ptr + i) % N;
                    n.active = 1;
                end
            n.ptr = n.win;
            n.cur = pat[n.win*PW +: PW];
            n.t   = 0;
        end
        return n;
    endfunction

    function automatic logic [3:0] e_gnt(input mdl_t m);
        return (m.active && m.t == 0) ? 4'(1 << m.win) : 4'b0;
    endfunction
    function automatic logic e_vld(input mdl_t m);
        return m.active && m.t < PW;
    endfunction
    function automatic logic e_ser(input mdl_t m);
        return e_vld(m) ? m.cur[PW-1-m.t] : 1'b0;
    endfunction
    function automatic logic e_done(input mdl_t m);
        return m.active && m.t == PW - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 = mreset();
            m1 = mreset();
        end else begin
            m0 = mstep(m0, req0, pat0, 2);
            m1 = mstep(m1, req1, pat1, 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt0",  32'(gnt0),  32'(e_gnt(m0)));
        chk("ser0",  32'(ser0),  32'(e_ser(m0)));
        chk("vld0",  32'(sv0),   32'(e_vld(m0)));
        chk("done0", 32'(done0), 32'(e_done(m0)));
        chk("busy0", 32'(busy0), 32'(m0.active));
        chk("gnt1",  32'(gnt1),  32'(e_gnt(m1)));
        chk("ser1",  32'(ser1),  32'(e_ser(m1)));
        chk("vld1",  32'(sv1),   32'(e_vld(m1)));
        chk("done1", 32'(done1), 32'(e_done(m1)));
        chk("busy1", 32'(busy1), 32'(m1.active));
    endtask

    // Advance one clock and compare at the following falling edge.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic int oh2i(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    int         gi [5];
    int         gc [5];
    int         n, nb, nd, nv, g1;
    bit         got;
    logic [7:0] bits;

    initial begin
        req0 = '0; pat0 = '0; req1 = '0; pat1 = '0;
        m0 = mreset(); m1 = mreset();
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(gnt0),  32'h0);
        chk("rst_ser",  32'(ser0),  32'h0);
        chk("rst_vld",  32'(sv0),   32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        rst_n = 1'b1;

        // 1: single request, A5, gap of two cycles
        req0 = 4'b0001; pat0 = 32'h000000A5;
        cyc();
        chk("t1_gnt", 32'(gnt0), 32'h1);
        req0 = '0;
        bits = '0;
        for (int i = 0; i < PW; i++) begin
            if (i > 0) cyc();
            bits = {bits[6:0], ser0};
            chk("t1_vld",  32'(sv0),   32'h1);
            chk("t1_done", 32'(done0), 32'(i == PW - 1));
        end
        chk("t1_bits", 32'(bits), 32'hA5);
        cyc(); chk("t1_gap1_busy", 32'(busy0), 32'h1); chk("t1_gap1_vld", 32'(sv0), 32'h0);
        cyc(); chk("t1_gap2_busy", 32'(busy0), 32'h1);
        cyc(); chk("t1_idle_busy", 32'(busy0), 32'h0);

        // 2: all four requesting from a fresh pointer
        do_reset();
        req0 = 4'b1111; pat0 = 32'h88442211;
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            cyc();
            if (gnt0 != 4'b0) begin
                gi[n] = oh2i(gnt0); gc[n] = cycle; n++;
            end
        end
        chk("t2_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) begin
            chk("t2_order", 32'(gi[i]), 32'(i % 4));
            if (i > 0) chk("t2_spacing", 32'(gc[i] - gc[i-1]), 32'd11);
        end
        req0 = '0;
        repeat (12) cyc();

        // 3: pattern and request change after the grant
        req0 = 4'b0100; pat0 = 32'h00F00000;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            got = gnt0[2];
        end
        chk("t3_gnt", 32'(got), 32'h1);
        bits = {7'b0, ser0}; nb = 1; nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) begin pat0[23:16] = 8'h0F; req0 = '0; end
            cyc();
            if (sv0) begin bits = {bits[6:0], ser0}; nb++; end
            if (done0) nd++;
        end
        chk("t3_nbits", 32'(nb), 32'd8);
        chk("t3_bits",  32'(bits), 32'hF0);
        chk("t3_done",  32'(nd), 32'd1);

        // 6: one-cycle pulse on requester 1 during SHIFT
        req0 = 4'b0001; pat0 = 32'h0000005A;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            got = gnt0[0];
        end
        chk("t6_gnt", 32'(got), 32'h1);
        req0 = 4'b0010;
        cyc();
        req0 = '0;
        g1 = 0; nv = sv0 ? 1 : 0;
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (gnt0[1]) g1++;
            if (sv0) nv++;
        end
        chk("t6_no_gnt1", 32'(g1), 32'd0);
        chk("t6_valid",   32'(nv), 32'd7);

        // 4: asynchronous reset during bit 4
        req0 = 4'b0001; pat0 = 32'h000000FF;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            cyc();
            got = gnt0[0];
        end
        chk("t4_gnt0", 32'(got), 32'h1);
        req0 = '0;
        repeat (4) cyc();
        chk("t4_pre_vld", 32'(sv0), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_gnt",  32'(gnt0),  32'h0);
        chk("t4_async_ser",  32'(ser0),  32'h0);
        chk("t4_async_vld",  32'(sv0),   32'h0);
        chk("t4_async_done", 32'(done0), 32'h0);
        chk("t4_async_busy", 32'(busy0), 32'h0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        req0 = 4'b1000; pat0 = 32'h96000000;
        cyc();
        chk("t4_gnt3", 32'(gnt0), 32'h8);
        chk("t4_msb",  32'(ser0), 32'h1);
        req0 = '0;
        repeat (12) cyc();

        // 5: zero-gap instance, two requesters held
        req1 = 4'b0011; pat1 = 32'h0000C33C;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            cyc();
            if (gnt1 != 4'b0) begin
                gi[n] = oh2i(gnt1); gc[n] = cycle; n++;
            end
        end
        chk("t5_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) begin
            chk("t5_order", 32'(gi[i]), 32'(i % 2));
            if (i > 0) chk("t5_spacing", 32'(gc[i] - gc[i-1]), 32'(PW + 1));
        end
        req1 = '0;
        repeat (10) cyc();

        // Random traffic on both instances against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req0 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) pat0 = $urandom;
            if ($urandom_range(0, 3) == 0) req1 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) pat1 = $urandom;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
